// File: rtl/scalar_bank_requester.sv
// scalar_bank_requester: splits byte/half/word requests into bank accesses and reassembles read data.
module scalar_bank_requester #(
  parameter int BYTE_AW = 12,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic               req_we,
  input  logic [1:0]         req_len,
  input  logic [BYTE_AW-1:0] req_adr,
  input  logic [DW-1:0]      req_din,
  output logic               resp_vld,
  output logic [DW-1:0]      resp_dout,
  output logic               err_len,
  output logic               bank_re,
  output logic               bank_we,
  output logic [1:0]         bank_len,
  output logic [BYTE_AW-1:0] bank_adr,
  output logic [DW-1:0]      bank_din,
  input  logic [DW-1:0]      bank_dout,
  input  logic               bank_dout_vld
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, mis_q, mis_d;
  logic [1:0] len_q, len_d, r_q, r_d;
  logic [2:0] n_q, n_d, k_q, k_d;
  logic [BYTE_AW-1:0] adr_q, adr_d;
  logic [DW-1:0] din_q, din_d, rx_q, rx_d, rx_nxt, mask;
  logic bank_re_q, bank_re_d, bank_we_q, bank_we_d;
  logic [1:0] bank_len_q, bank_len_d;
  logic [BYTE_AW-1:0] bank_adr_q, bank_adr_d;
  logic [DW-1:0] bank_din_q, bank_din_d;
  logic resp_vld_q, resp_vld_d, err_len_q, err_len_d;
  logic [DW-1:0] resp_dout_q, resp_dout_d;
  logic [1:0] acc_len;
  logic acc_mis, cap, last;
  assign acc_len = req_len == 2'd2 ? 2'd0 : req_len;
  assign acc_mis = (acc_len == 2'd1 && req_adr[0]) || (acc_len == 2'd3 && req_adr[1:0] != 2'd0);
  // Read data may arrive while later accesses are still being issued.
  assign cap = state_q != IDLE && !we_q && bank_dout_vld;
  assign last = {1'b0, r_q} == n_q - 3'd1;
  assign mask = {{(DW-16){len_q[1]}}, {8{len_q[0]}}, 8'hFF};
  assign req_rdy = state_q == IDLE;
  assign bank_re = bank_re_q;
  assign bank_we = bank_we_q;
  assign bank_len = bank_len_q;
  assign bank_adr = bank_adr_q;
  assign bank_din = bank_din_q;
  assign resp_vld = resp_vld_q;
  assign resp_dout = resp_dout_q;
  assign err_len = err_len_q;
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    mis_d = mis_q;
    len_d = len_q;
    adr_d = adr_q;
    din_d = din_q;
    n_d = n_q;
    k_d = k_q;
    r_d = r_q;
    rx_d = rx_q;
    bank_re_d = 1'b0;
    bank_we_d = 1'b0;
    bank_len_d = bank_len_q;
    bank_adr_d = bank_adr_q;
    bank_din_d = bank_din_q;
    resp_vld_d = 1'b0;
    resp_dout_d = resp_dout_q;
    err_len_d = 1'b0;
    rx_nxt = rx_q;
    rx_nxt[8*r_q +: 8] = bank_dout[7:0];
    if (state_q == IDLE && req_vld) begin
      state_d = ISSUE;
      we_d = req_we;
      len_d = acc_len;
      adr_d = req_adr;
      din_d = req_din;
      mis_d = acc_mis;
      n_d = acc_mis ? (acc_len == 2'd1 ? 3'd2 : 3'd4) : 3'd1;
      k_d = 3'd1;
      r_d = 2'd0;
      rx_d = '0;
      err_len_d = req_len == 2'd2;
      bank_re_d = !req_we;
      bank_we_d = req_we;
      bank_len_d = acc_mis ? 2'd0 : acc_len;
      bank_adr_d = req_adr;
      bank_din_d = acc_mis ? {{(DW-8){1'b0}}, req_din[7:0]} : req_din;
    end
    if (state_q == ISSUE) begin
      if (k_q == n_q) begin
        state_d = we_q ? IDLE : WAIT;
      end else begin
        bank_re_d = !we_q;
        bank_we_d = we_q;
        bank_len_d = 2'd0;
        bank_adr_d = adr_q + BYTE_AW'(k_q);
        bank_din_d = {{(DW-8){1'b0}}, din_q[8*k_q[1:0] +: 8]};
        k_d = k_q + 3'd1;
      end
    end
    if (cap && mis_q) begin
      rx_d = rx_nxt;
      r_d = r_q + 2'd1;
      resp_vld_d = last;
      resp_dout_d = last ? rx_nxt : resp_dout_q;
      state_d = last ? IDLE : state_d;
    end else if (cap) begin
      resp_vld_d = 1'b1;
      resp_dout_d = bank_dout & mask;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      mis_q <= 1'b0;
      len_q <= '0;
      adr_q <= '0;
      din_q <= '0;
      n_q <= '0;
      k_q <= '0;
      r_q <= '0;
      rx_q <= '0;
      bank_re_q <= 1'b0;
      bank_we_q <= 1'b0;
      bank_len_q <= '0;
      bank_adr_q <= '0;
      bank_din_q <= '0;
      resp_vld_q <= 1'b0;
      resp_dout_q <= '0;
      err_len_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      mis_q <= mis_d;
      len_q <= len_d;
      adr_q <= adr_d;
      din_q <= din_d;
      n_q <= n_d;
      k_q <= k_d;
      r_q <= r_d;
      rx_q <= rx_d;
      bank_re_q <= bank_re_d;
      bank_we_q <= bank_we_d;
      bank_len_q <= bank_len_d;
      bank_adr_q <= bank_adr_d;
      bank_din_q <= bank_din_d;
      resp_vld_q <= resp_vld_d;
      resp_dout_q <= resp_dout_d;
      err_len_q <= err_len_d;
    end
  end
endmodule

// File: tb/tb_scalar_bank_requester.sv
// tb_scalar_bank_requester: byte-array reference model and scoreboarded bank accesses and read responses.
module tb_scalar_bank_requester;
  localparam int AW = 12;
  logic clk = 1'b0, rst = 1'b1;
  logic req_vld = 1'b0, req_we = 1'b0;
  logic [1:0] req_len = '0;
  logic [AW-1:0] req_adr = '0;
  logic [31:0] req_din = '0;
  logic req_rdy, resp_vld, err_len, bank_re, bank_we;
  logic [31:0] resp_dout, bank_din;
  logic [1:0] bank_len;
  logic [AW-1:0] bank_adr;
  logic [31:0] bank_dout = '0;
  logic bank_dout_vld = 1'b0;
  int unsigned cyc = 0;
  int n_cmp = 0, n_err = 0;
  typedef struct packed {logic we; logic [1:0] len; logic [AW-1:0] adr; logic [31:0] din;} acc_t;
  typedef struct packed {logic [31:0] d; logic [31:0] c;} resp_t;
  acc_t acc_q[$];
  resp_t resp_q[$];
  logic [7:0] bmem [4096] = '{default: 8'h00};
  logic [7:0] rmem [4096] = '{default: 8'h00};

  scalar_bank_requester #(.BYTE_AW(AW), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we), .req_len(req_len),
    .req_adr(req_adr), .req_din(req_din),
    .resp_vld(resp_vld), .resp_dout(resp_dout), .err_len(err_len),
    .bank_re(bank_re), .bank_we(bank_we), .bank_len(bank_len), .bank_adr(bank_adr),
    .bank_din(bank_din), .bank_dout(bank_dout), .bank_dout_vld(bank_dout_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int nbytes(input logic [1:0] l);
    return l == 2'd3 ? 4 : int'(l) + 1;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bank: 1-cycle read latency, right-justified data with junk in unused upper bytes.
  always @(posedge clk) begin
    logic [31:0] v;
    v = $urandom;
    for (int i = 0; i < 4; i++)
      if (i < nbytes(bank_len)) v[8*i +: 8] = bmem[AW'(int'(bank_adr) + i)];
    bank_dout <= v;
    bank_dout_vld <= bank_re;
    if (bank_we)
      for (int i = 0; i < 4; i++)
        if (i < nbytes(bank_len)) bmem[AW'(int'(bank_adr) + i)] <= bank_din[8*i +: 8];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bank_re || bank_we) begin
        check("re_we_excl", 64'(bank_re & bank_we), 64'd0);
        if (acc_q.size() == 0) check("acc_unexpected", 64'(bank_re | bank_we), 64'd0);
        else check("acc", 64'({bank_we, bank_len, bank_adr, bank_din}), 64'(acc_q.pop_front()));
      end
      if (resp_vld) begin
        if (resp_q.size() == 0) check("resp_unexpected", 64'(resp_vld), 64'd0);
        else begin
          resp_t r;
          r = resp_q.pop_front();
          check("resp_dout", 64'(resp_dout), 64'(r.d));
          check("resp_cycle", 64'(cyc), 64'(r.c));
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge where req_rdy is back.
  task automatic do_req(input logic we, input logic [1:0] len, input logic [AW-1:0] adr, input logic [31:0] din);
    logic [1:0] el;
    logic [31:0] exp;
    bit mis;
    int n, t, g;
    acc_t a;
    el = len == 2'd2 ? 2'd0 : len;
    mis = (el == 2'd1 && adr[0]) || (el == 2'd3 && adr[1:0] != 2'd0);
    n = mis ? (el == 2'd1 ? 2 : 4) : 1;
    g = 0;
    while (!req_rdy && g < 40) begin @(negedge clk); g++; end
    check("rdy_before_req", 64'(req_rdy), 64'd1);
    t = int'(cyc) + 1;
    for (int i = 0; i < n; i++) begin
      a.we = we;
      a.len = mis ? 2'd0 : el;
      a.adr = AW'(int'(adr) + i);
      a.din = mis ? {24'h0, din[8*i +: 8]} : din;
      acc_q.push_back(a);
    end
    exp = '0;
    for (int i = 0; i < nbytes(el); i++) begin
      if (we) rmem[AW'(int'(adr) + i)] = din[8*i +: 8];
      else exp[8*i +: 8] = rmem[AW'(int'(adr) + i)];
    end
    if (!we) resp_q.push_back('{d: exp, c: 32'(t + (mis ? n + 2 : 3) - 1)});
    req_vld = 1'b1; req_we = we; req_len = len; req_adr = adr; req_din = din;
    @(negedge clk);
    req_vld = 1'b0;
    check("err_len", 64'(err_len), 64'(len == 2'd2));
    g = 0;
    while (!req_rdy && g < 40) begin @(negedge clk); g++; end
    check("rdy_latency", 64'(int'(cyc) - t + 1), 64'(we ? n + 1 : n + 2));
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({bank_re, bank_we, bank_len, bank_adr, bank_din, resp_vld, err_len}), 64'd0);
    check("reset_dout", 64'(resp_dout), 64'd0);
    check("reset_rdy", 64'(req_rdy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b1, 2'd3, 12'h010, 32'h44332211);
    do_req(1'b0, 2'd3, 12'h010, 32'h0);
    do_req(1'b0, 2'd1, 12'h011, 32'h0);
    do_req(1'b1, 2'd3, 12'h013, 32'hAABBCCDD);
    do_req(1'b0, 2'd3, 12'h013, 32'h0);
    do_req(1'b1, 2'd3, 12'hFFE, 32'h87654321);
    do_req(1'b0, 2'd3, 12'hFFE, 32'h0);
    do_req(1'b0, 2'd1, 12'h000, 32'h0);
    do_req(1'b0, 2'd2, 12'h012, 32'h0);
    // Misaligned word read cut short by reset after its second access.
    t = int'(cyc) + 1;
    for (int i = 0; i < 2; i++) acc_q.push_back('{we: 1'b0, len: 2'd0, adr: AW'(12'h013 + i), din: 32'h0});
    req_vld = 1'b1; req_we = 1'b0; req_len = 2'd3; req_adr = 12'h013; req_din = '0;
    @(negedge clk);
    req_vld = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    acc_q.delete();
    resp_q.delete();
    @(negedge clk);
    check("rst_bank_re", 64'(bank_re), 64'd0);
    #2 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_quiet", 64'({bank_re, bank_we, resp_vld}), 64'd0);
      check("post_rst_rdy", 64'(req_rdy), 64'd1);
    end
    check("rst_cycle_seen", 64'(int'(cyc) > t + 2), 64'd1);
    do_req(1'b0, 2'd3, 12'h013, 32'h0);
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), AW'($urandom), $urandom);
    end
    repeat (5) @(negedge clk);
    check("acc_left", 64'(acc_q.size()), 64'd0);
    check("resp_left", 64'(resp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
